// File: rtl/ps2_pkg.sv
// Shared constants and FSM encoding for the PS/2 set-2 key decoder.
package ps2_pkg;

  // Prefix bytes of scan-code set 2
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  // Parser state, one transition per parsed byte
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXT    = 3'd1,
    S_BRK    = 3'd2,
    S_EXTBRK = 3'd3,
    S_SKIP   = 3'd4
  } state_t;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational ROM: set-2 scan code to lower-case ASCII, 8'h00 when unmapped.
module ps2_scan2ascii (
  input  logic [7:0] i_code,
  output logic [7:0] o_ascii
);

  // Case ROM covering letters, digits, space, enter, tab and basic punctuation
  always_comb begin
    o_ascii = 8'h00;
    case (i_code)
      8'h1C: o_ascii = 8'h61; // a
      8'h32: o_ascii = 8'h62; // b
      8'h21: o_ascii = 8'h63; // c
      8'h23: o_ascii = 8'h64; // d
      8'h24: o_ascii = 8'h65; // e
      8'h2B: o_ascii = 8'h66; // f
      8'h34: o_ascii = 8'h67; // g
      8'h33: o_ascii = 8'h68; // h
      8'h43: o_ascii = 8'h69; // i
      8'h3B: o_ascii = 8'h6A; // j
      8'h42: o_ascii = 8'h6B; // k
      8'h4B: o_ascii = 8'h6C; // l
      8'h3A: o_ascii = 8'h6D; // m
      8'h31: o_ascii = 8'h6E; // n
      8'h44: o_ascii = 8'h6F; // o
      8'h4D: o_ascii = 8'h70; // p
      8'h15: o_ascii = 8'h71; // q
      8'h2D: o_ascii = 8'h72; // r
      8'h1B: o_ascii = 8'h73; // s
      8'h2C: o_ascii = 8'h74; // t
      8'h3C: o_ascii = 8'h75; // u
      8'h2A: o_ascii = 8'h76; // v
      8'h1D: o_ascii = 8'h77; // w
      8'h22: o_ascii = 8'h78; // x
      8'h35: o_ascii = 8'h79; // y
      8'h1A: o_ascii = 8'h7A; // z
      8'h45: o_ascii = 8'h30; // 0
      8'h16: o_ascii = 8'h31; // 1
      8'h1E: o_ascii = 8'h32; // 2
      8'h26: o_ascii = 8'h33; // 3
      8'h25: o_ascii = 8'h34; // 4
      8'h2E: o_ascii = 8'h35; // 5
      8'h36: o_ascii = 8'h36; // 6
      8'h3D: o_ascii = 8'h37; // 7
      8'h3E: o_ascii = 8'h38; // 8
      8'h46: o_ascii = 8'h39; // 9
      8'h29: o_ascii = 8'h20; // space
      8'h5A: o_ascii = 8'h0D; // enter
      8'h0D: o_ascii = 8'h09; // tab
      8'h4E: o_ascii = 8'h2D; // -
      8'h55: o_ascii = 8'h3D; // =
      8'h54: o_ascii = 8'h5B; // [
      8'h5B: o_ascii = 8'h5D; // ]
      8'h5D: o_ascii = 8'h5C; // backslash
      8'h4C: o_ascii = 8'h3B; // ;
      8'h52: o_ascii = 8'h27; // '
      8'h41: o_ascii = 8'h2C; // ,
      8'h49: o_ascii = 8'h2E; // .
      8'h4A: o_ascii = 8'h2F; // /
      8'h0E: o_ascii = 8'h60; // `
      default: o_ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: pops bytes from the keyboard FIFO, strips E0/F0/E1
// prefixes and emits one key event per completed sequence.
//
// Pop handshake: a byte is taken when ps2_ready=1 while nextdata_n=1; that
// edge latches ps2_data and drives nextdata_n low for exactly one cycle, so
// the FIFO advances on the following edge. nextdata_n then stays high for at
// least one cycle, giving at most one byte every two clocks. The latched byte
// is parsed the cycle after the pop; key_valid is a one-cycle pulse.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int COUNT_W = 8,
  parameter int E1_SKIP = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         ps2_data,
  input  logic               ps2_ready,
  input  logic               ps2_overflow,
  output logic               nextdata_n,
  output logic               key_valid,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               key_make,
  output logic               key_repeat,
  output logic [7:0]         key_ascii,
  output logic               key_held,
  output logic [COUNT_W-1:0] press_count,
  output logic               err_sticky,
  output logic [2:0]         dbg_state
);

  state_t             r_state;
  logic [7:0]         r_skip_cnt;
  logic               r_nextdata_n;
  logic [7:0]         r_byte_q;
  logic               r_byte_v;
  logic               r_key_valid;
  logic [7:0]         r_key_code;
  logic               r_key_ext;
  logic               r_key_make;
  logic               r_key_repeat;
  logic [7:0]         r_key_ascii;
  logic               r_key_held;
  logic [8:0]         r_held;
  logic [COUNT_W-1:0] r_press_count;
  logic               r_err;

  state_t             w_state_nxt;
  logic [7:0]         w_skip_nxt;
  logic               w_pop;
  logic               w_ev;
  logic               w_ev_make;
  logic               w_ev_ext;
  logic               w_match;
  logic [7:0]         w_ascii;

  ps2_scan2ascii u_scan2ascii (
    .i_code  (r_byte_q),
    .o_ascii (w_ascii)
  );

  // Next-state decode: pop request, prefix FSM and event generation
  always_comb begin
    w_pop       = ps2_ready && r_nextdata_n;
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip_cnt;
    w_ev        = 1'b0;
    w_ev_make   = 1'b0;
    w_ev_ext    = 1'b0;
    if (r_byte_v) begin
      case (r_state)
        S_IDLE: begin
          if (r_byte_q == SC_EXT) begin
            w_state_nxt = S_EXT;
          end else if (r_byte_q == SC_BRK) begin
            w_state_nxt = S_BRK;
          end else if (r_byte_q == SC_PAUSE) begin
            w_state_nxt = S_SKIP;
            w_skip_nxt  = 8'(E1_SKIP);
          end else begin
            w_ev      = 1'b1;
            w_ev_make = 1'b1;
          end
        end
        S_EXT: begin
          if (r_byte_q == SC_BRK) begin
            w_state_nxt = S_EXTBRK;
          end else if ((r_byte_q != SC_EXT) && (r_byte_q != SC_PAUSE)) begin
            w_ev        = 1'b1;
            w_ev_make   = 1'b1;
            w_ev_ext    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          w_ev        = 1'b1;
          w_state_nxt = S_IDLE;
        end
        S_EXTBRK: begin
          w_ev        = 1'b1;
          w_ev_ext    = 1'b1;
          w_state_nxt = S_IDLE;
        end
        S_SKIP: begin
          w_skip_nxt = r_skip_cnt - 8'd1;
          if (r_skip_cnt <= 8'd1) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    // Overflow drops any partial sequence and suppresses a completing event
    if (ps2_overflow) begin
      w_state_nxt = S_IDLE;
      w_ev        = 1'b0;
    end
    w_match = r_key_held && (r_held == {w_ev_ext, r_byte_q});
  end

  // State, handshake, event fields, held-key register and press counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_skip_cnt    <= 8'd0;
      r_nextdata_n  <= 1'b1;
      r_byte_q      <= 8'd0;
      r_byte_v      <= 1'b0;
      r_key_valid   <= 1'b0;
      r_key_code    <= 8'd0;
      r_key_ext     <= 1'b0;
      r_key_make    <= 1'b0;
      r_key_repeat  <= 1'b0;
      r_key_ascii   <= 8'd0;
      r_key_held    <= 1'b0;
      r_held        <= 9'd0;
      r_press_count <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_skip_cnt   <= w_skip_nxt;
      r_nextdata_n <= !w_pop;
      r_byte_v     <= w_pop;
      if (w_pop) begin
        r_byte_q <= ps2_data;
      end
      r_err       <= r_err | ps2_overflow;
      r_key_valid <= w_ev;
      if (w_ev) begin
        r_key_code   <= r_byte_q;
        r_key_ext    <= w_ev_ext;
        r_key_make   <= w_ev_make;
        r_key_repeat <= w_ev_make && w_match;
        r_key_ascii  <= w_ev_ext ? 8'h00 : w_ascii;
        if (w_ev_make && !w_match) begin
          r_held        <= {w_ev_ext, r_byte_q};
          r_key_held    <= 1'b1;
          r_press_count <= r_press_count + COUNT_W'(1);
        end else if (!w_ev_make && w_match) begin
          r_key_held <= 1'b0;
        end
      end
    end
  end

  assign nextdata_n  = r_nextdata_n;
  assign key_valid   = r_key_valid;
  assign key_code    = r_key_code;
  assign key_ext     = r_key_ext;
  assign key_make    = r_key_make;
  assign key_repeat  = r_key_repeat;
  assign key_ascii   = r_key_ascii;
  assign key_held    = r_key_held;
  assign press_count = r_press_count;
  assign err_sticky  = r_err;
  assign dbg_state   = r_state;

endmodule
